// File: rtl/des_out_reader.sv
// Read-side DES result collector: buffers 64-bit blocks in a FIFO and streams them MSB byte first.
// Optional XOR checksum beat after every block when DES_READER_CHECKSUM_EN is defined.
module des_out_reader #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic [DATA_WIDTH:1] i_data,
  input  logic                i_valid,
  output logic [7:0]          o_byte,
  output logic                o_byte_valid,
  input  logic                i_byte_ready,
  output logic                o_last,
  output logic [ADDR_WIDTH:0] count,
  output logic                full,
  output logic                empty,
  output logic                overflow,
  input  logic                clr_overflow
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DepthCnt = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CntOne   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PtrOne   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

`ifdef DES_READER_CHECKSUM_EN
  typedef enum logic [1:0] {StIdle, StLoad, StSend, StChk} state_e;
`else
  typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;
`endif

  state_e state_q, state_d;

  logic [DATA_WIDTH:1]   mem [0:Depth-1];
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  overflow_q;
  logic [DATA_WIDTH:1]   shifter_q;
  logic [3:0]            beat_q;
`ifdef DES_READER_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  logic pop;
  logic push;
  logic drop;
  logic send_xfer;

  assign count    = count_q;
  assign full     = (count_q == DepthCnt);
  assign empty    = (count_q == '0);
  assign overflow = overflow_q;

  // A full FIFO still accepts a block when the head leaves in the same cycle.
  assign push = i_valid & (~full | pop);
  assign drop = i_valid & ~push;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    send_xfer    = 1'b0;
    o_byte_valid = 1'b0;
    o_byte       = 8'h00;
    o_last       = 1'b0;
    case (state_q)
      StIdle: begin
        if (count_q != '0) state_d = StLoad;
      end
      StLoad: begin
        pop     = 1'b1;
        state_d = StSend;
      end
      StSend: begin
        o_byte_valid = 1'b1;
        o_byte       = shifter_q[DATA_WIDTH -: 8];
`ifndef DES_READER_CHECKSUM_EN
        o_last       = (beat_q == 4'd7);
`endif
        if (i_byte_ready) begin
          send_xfer = 1'b1;
          if (beat_q == 4'd7) begin
`ifdef DES_READER_CHECKSUM_EN
            state_d = StChk;
`else
            state_d = (count_q != '0) ? StLoad : StIdle;
`endif
          end
        end
      end
`ifdef DES_READER_CHECKSUM_EN
      StChk: begin
        o_byte_valid = 1'b1;
        o_byte       = csum_q;
        o_last       = 1'b1;
        if (i_byte_ready) state_d = (count_q != '0) ? StLoad : StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Storage carries no reset; pointers and count define which entries are live.
  always_ff @(posedge rd_clk) begin
    if (push) mem[wr_ptr_q] <= i_data;
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      shifter_q  <= '0;
      beat_q     <= 4'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;

      case ({push, pop})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase

      if (clr_overflow) begin
        overflow_q <= 1'b0;
      end else if (drop) begin
        overflow_q <= 1'b1;
      end

      if (pop) begin
        shifter_q <= mem[rd_ptr_q];
        beat_q    <= 4'd0;
      end else if (send_xfer) begin
        shifter_q <= {shifter_q[DATA_WIDTH-8:1], 8'h00};
        beat_q    <= beat_q + 4'd1;
      end
    end
  end

`ifdef DES_READER_CHECKSUM_EN
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      csum_q <= 8'h00;
    end else if (pop) begin
      csum_q <= 8'h00;
    end else if (send_xfer) begin
      csum_q <= csum_q ^ shifter_q[DATA_WIDTH -: 8];
    end
  end
`endif

endmodule

// File: tb/tb_des_out_reader.sv
// Self-checking bench for des_out_reader: directed vector table, corner sequences and a
// randomized run scored against a queue-based reference model.
module tb_des_out_reader;

`ifdef DES_READER_CHECKSUM_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam int DEPTH = 16;

  logic        rd_clk = 1'b0;
  logic        rd_rst;
  logic [64:1] i_data;
  logic        i_valid;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic        i_byte_ready;
  logic        o_last;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        clr_overflow;

  des_out_reader dut (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_byte       (o_byte),
    .o_byte_valid (o_byte_valid),
    .i_byte_ready (i_byte_ready),
    .o_last       (o_last),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 rd_clk = ~rd_clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int first_cyc;
  bit chk_en  = 1'b0;

  // Reference model: queued blocks, bytes still owed for the current block, pending bubble.
  logic [63:0] m_fifo[$];
  logic [7:0]  m_cur[$];
  bit          m_load = 1'b0;
  bit          m_ovf  = 1'b0;

  logic [8:0]  cap[$];
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_byte;
  logic        prev_last;

  typedef struct {
    logic [63:0]     data;
    bit              toggle;
    logic [0:7][7:0] bytes;
    logic [7:0]      chk;
  } vec_t;
  vec_t vecs[5];
  logic [3:0]  pat = 4'b1001;
  logic [63:0] blks[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_load(input logic [63:0] blk);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    m_cur.delete();
    for (int j = 0; j < 8; j++) begin
      b = 8'((blk >> (8 * (7 - j))) & 64'hFF);
      m_cur.push_back(b);
      x = x ^ b;
    end
`ifdef DES_READER_CHECKSUM_EN
    m_cur.push_back(x);
`endif
  endtask

  // One clock: compare at the falling edge, advance the model, return 1 time unit past the edge.
  task automatic tick();
    bit mv, pop, xfer, push;
    int pre;
    logic [63:0] blk;
    @(negedge rd_clk);
    mv = (m_cur.size() != 0);
    if (chk_en) begin
      check("m_valid", o_byte_valid, mv);
      if (mv) begin
        check("m_byte", o_byte, m_cur[0]);
        check("m_last", o_last, m_cur.size() == 1);
      end
      check("m_count", count, m_fifo.size());
      check("m_full", full, m_fifo.size() == DEPTH);
      check("m_empty", empty, m_fifo.size() == 0);
      check("m_ovf", overflow, m_ovf);
      if (prev_stall) begin
        check("stall_byte", o_byte, prev_byte);
        check("stall_last", o_last, prev_last);
      end
      if (o_byte_valid && i_byte_ready) cap.push_back({o_last, o_byte});
      if (o_byte_valid && first_cyc < 0) first_cyc = cyc;
    end
    prev_stall = o_byte_valid && !i_byte_ready && !rd_rst;
    prev_byte  = o_byte;
    prev_last  = o_last;
    if (rd_rst) begin
      m_fifo.delete();
      m_cur.delete();
      m_load = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      pre  = m_fifo.size();
      pop  = m_load;
      xfer = mv && i_byte_ready;
      push = i_valid && (pre < DEPTH || pop);
      if (pop) begin
        blk = m_fifo.pop_front();
        model_load(blk);
        m_load = 1'b0;
      end else if (xfer) begin
        void'(m_cur.pop_front());
        if (m_cur.size() == 0) m_load = (pre != 0);
      end else if (m_cur.size() == 0) begin
        m_load = (pre != 0);
      end
      if (push) m_fifo.push_back(i_data);
      if (clr_overflow) m_ovf = 1'b0;
      else if (i_valid && !push) m_ovf = 1'b1;
    end
    @(posedge rd_clk);
    cyc++;
    #1;
  endtask

  task automatic run_vec(input int idx);
    int strobe_cyc;
    int p;
    logic [8:0] want;
    cap.delete();
    first_cyc    = -1;
    i_data       = vecs[idx].data;
    i_valid      = 1'b1;
    i_byte_ready = 1'b1;
    strobe_cyc   = cyc;
    tick();
    i_valid = 1'b0;
    p = 1;
    while (cap.size() < NB && p < 80) begin
      i_byte_ready = vecs[idx].toggle ? pat[p % 4] : 1'b1;
      tick();
      p++;
    end
    i_byte_ready = 1'b1;
    check($sformatf("v%0d_nbytes", idx), cap.size(), NB);
    check($sformatf("v%0d_latency", idx), first_cyc - strobe_cyc, 3);
    for (int j = 0; j < NB && j < cap.size(); j++) begin
      if (j < 8) want = {(j == NB - 1), vecs[idx].bytes[j]};
      else       want = {1'b1, vecs[idx].chk};
      check($sformatf("v%0d_beat%0d", idx, j), cap[j], want);
    end
  endtask

  initial begin
    logic [63:0] got;
    logic [63:0] exp_blk;

    vecs[0] = '{64'h0EB9460100C38224, 1'b0,
                {8'h0E, 8'hB9, 8'h46, 8'h01, 8'h00, 8'hC3, 8'h82, 8'h24}, 8'h95};
    vecs[1] = '{64'h0EB9460100C38224, 1'b1,
                {8'h0E, 8'hB9, 8'h46, 8'h01, 8'h00, 8'hC3, 8'h82, 8'h24}, 8'h95};
    vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 1'b0,
                {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 8'h00};
    vecs[3] = '{64'h0102030405060708, 1'b1,
                {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}, 8'h08};
    vecs[4] = '{64'h8000000000000001, 1'b0,
                {8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01}, 8'h81};

    // Reset held for two cycles, then idle.
    rd_rst       = 1'b1;
    i_valid      = 1'b0;
    i_data       = '0;
    i_byte_ready = 1'b0;
    clr_overflow = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_byte", o_byte, 8'h00);
    check("rst_valid", o_byte_valid, 1'b0);
    check("rst_last", o_last, 1'b0);
    check("rst_count", count, 5'd0);
    check("rst_full", full, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_ovf", overflow, 1'b0);
    rd_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_valid", o_byte_valid, 1'b0);
      check("idle_empty", empty, 1'b1);
    end

    // Directed blocks, with and without back-pressure.
    for (int v = 0; v < 5; v++) run_vec(v);

    // Overflow: 18 strobes while the sink is stalled.
    cap.delete();
    i_byte_ready = 1'b0;
    for (int i = 0; i < 19; i++) blks[i] = {$urandom, $urandom};
    for (int i = 0; i < 18; i++) begin
      i_data  = blks[i];
      i_valid = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    check("ovf_full", full, 1'b1);
    check("ovf_count", count, 5'd16);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_head_valid", o_byte_valid, 1'b1);
    check("ovf_head_byte", o_byte, blks[0][63:56]);

    // Push into a full FIFO during the LOAD bubble.
    i_byte_ready = 1'b1;
    for (int t = 0; t < 40 && cap.size() < NB; t++) tick();
    check("full_push_b1_done", cap.size(), NB);
    i_data  = blks[18];
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    check("full_push_count", count, 5'd16);
    check("full_push_full", full, 1'b1);
    check("full_push_ovf", overflow, 1'b1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("clr_ovf", overflow, 1'b0);
    for (int t = 0; t < 400 && cap.size() < 18 * NB; t++) tick();
    check("drain_nbytes", cap.size(), 18 * NB);
    for (int k = 0; k < 18 && cap.size() >= 18 * NB; k++) begin
      exp_blk = (k < 17) ? blks[k] : blks[18];
      got = '0;
      for (int j = 0; j < 8; j++) got = {got[55:0], cap[k * NB + j][7:0]};
      check($sformatf("drain_blk%0d", k), got, exp_blk);
      check($sformatf("drain_last%0d", k), cap[k * NB + NB - 1][8], 1'b1);
    end

    // Reset on beat 4 with three blocks queued.
    cap.delete();
    i_byte_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_data  = {$urandom, $urandom};
      i_valid = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    check("mid_rst_queued", count, 5'd3);
    for (int t = 0; t < 40 && cap.size() < 3; t++) tick();
    check("mid_rst_beats", cap.size(), 3);
    i_byte_ready = 1'b0;
    rd_rst       = 1'b1;
    i_valid      = 1'b1;
    i_data       = {$urandom, $urandom};
    tick();
    rd_rst       = 1'b0;
    i_valid      = 1'b0;
    i_byte_ready = 1'b1;
    check("mid_rst_valid", o_byte_valid, 1'b0);
    check("mid_rst_count", count, 5'd0);
    check("mid_rst_empty", empty, 1'b1);
    check("mid_rst_last", o_last, 1'b0);
    run_vec(0);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      i_valid      = (c < 700) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) == 0);
      i_data       = {$urandom, $urandom};
      i_byte_ready = ($urandom_range(0, 3) != 0);
      clr_overflow = ($urandom_range(0, 63) == 0);
      rd_rst       = ($urandom_range(0, 399) == 0);
      tick();
    end
    i_valid      = 1'b0;
    rd_rst       = 1'b0;
    clr_overflow = 1'b0;
    i_byte_ready = 1'b1;
    for (int t = 0; t < 250; t++) tick();
    check("final_empty", empty, 1'b1);
    check("final_valid", o_byte_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/des_out_reader.md
# des_out_reader

- Read-side result collector for the DES system.
- Captures each 64-bit result presented with `o_valid` (connected here as `i_data`/`i_valid`), buffers it in a small synchronous FIFO, and streams it out one byte at a time over a valid/ready handshake.
- Sits on `rd_clk`, downstream of `sys_top`. It is the draining counterpart of the write-side FIFO feeder (`wr_incr`/`wr_data`).

## Interface
Parameters:
- `ADDR_WIDTH`, 4: FIFO address width; depth = 2^ADDR_WIDTH blocks.
- `DATA_WIDTH`, 64: block width; fixed at 64, and other values are unsupported.

Ports:
- `rd_clk`  in  1  single clock; all logic on rising edge.
- `rd_rst`  in  1  reset; synchronous, active-high.
- `i_data`  in  [64:1]  DES result block.
- `i_valid`  in  1  one-cycle strobe; `i_data` is valid while high.
- `o_byte`  out  8  current output byte.
- `o_byte_valid`  out  1  `o_byte` is valid.
- `i_byte_ready`  in  1  sink accepts `o_byte` this cycle.
- `o_last`  out  1  final beat of the current block; qualified by `o_byte_valid`.
- `count`  out  ADDR_WIDTH+1  blocks held in the FIFO, excluding the shifter.
- `full`  out  1  `count == 2^ADDR_WIDTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky; set when a block is dropped.
- `clr_overflow`  in  1  clears `overflow`.

## Operation
Reset values:
- `o_byte` = 0, `o_byte_valid` = 0, `o_last` = 0, `count` = 0, `full` = 0, `empty` = 1, `overflow` = 0.
- FSM enters IDLE; FIFO pointers are zeroed.

FIFO write:
- A block is pushed when `i_valid` is high and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- Otherwise the block is dropped and `overflow` is set.

FIFO read:
- A pop occurs only in LOAD.

Count update:
- Push and pop in the same cycle: `count` unchanged.
- Push only: `count` + 1.
- Pop only: `count` − 1.
- Pointers wrap modulo depth.

Overflow flag:
- `clr_overflow` has priority over a same-cycle set.

FSM:
- IDLE: go to LOAD when `count != 0`.
- LOAD:
  - Pop the head block into the 64-bit shifter.
  - Beat counter = 0; checksum register = 0.
  - Go to SEND.
- SEND:
  - `o_byte_valid` = 1; `o_byte` = shifter[64:57], so the MSB byte goes first.
  - On a transfer (`o_byte_valid && i_byte_ready`): shift left 8, increment the beat counter, XOR the byte into the checksum.
  - After beat 8 transfers: go to CHK if the macro is defined; otherwise go to LOAD if `count != 0`, else IDLE.
- CHK (macro only):
  - `o_byte` = checksum, `o_byte_valid` = 1, `o_last` = 1.
  - On transfer: go to LOAD if `count != 0`, else IDLE.

Output behaviour:
- `o_last` = 1 on beat 8 in SEND without the macro; otherwise `o_last` is high only in CHK.
- `o_byte` and `o_last` hold stable while `o_byte_valid && !i_byte_ready`.
- `o_byte_valid` never drops before its transfer.

## Timing
- `i_valid` sampled at edge k into an empty, idle block:
  - `count` = 1 after edge k.
  - LOAD after edge k+1.
  - `o_byte_valid` = 1 after edge k+2, so first-byte latency is 3 cycles.
- One bubble cycle (LOAD) separates consecutive blocks.
- Per-block throughput with `i_byte_ready` held high:
  - 9 cycles without the macro.
  - 10 cycles with the macro.
- `rd_rst` mid-block (any state):
  - All outputs take their reset values after that edge.
  - The partial block and all buffered blocks are discarded.
  - `i_valid` in the reset cycle is ignored.
- Flags timing: `full`, `empty` and `count` are registered and reflect the state after each edge.

## Configuration
- Macro: `DES_READER_CHECKSUM_EN`.
- Defined:
  - Each block is followed by a 9th beat carrying the XOR of its 8 bytes.
  - `o_last` marks the checksum beat.
- Undefined:
  - CHK state and checksum register are absent.
  - 8 beats per block; `o_last` marks beat 8.

## Test plan
1. Reset then idle, with `i_valid` = 0 and `rd_rst` pulsed for 2 cycles → all outputs at reset values, `empty` = 1, `o_byte_valid` = 0 throughout.
2. Single block `i_data` = 0x0EB9460100C38224, `i_byte_ready` = 1 → `o_byte_valid` rises 3 cycles after the strobe.
   - Bytes out: 0E B9 46 01 00 C3 82 24, with `o_last` on 24.
   - With the macro: a 9th byte 0x95 with `o_last`.
3. Back-pressure: same block, `i_byte_ready` toggling 1,0,0,1 repeating → identical byte sequence, no byte repeated or skipped, `o_byte` stable during stalls.
4. Overflow: 18 consecutive `i_valid` cycles with `i_byte_ready` = 0 →
   - block 1 in the shifter, blocks 2–17 in the FIFO;
   - `full` = 1, `count` = 16, `overflow` = 1, block 18 dropped;
   - releasing ready emits blocks 1–17 in order.
5. Push while full with a pop in the same LOAD cycle → block accepted, `count` stays 16, `overflow` unchanged; `clr_overflow` then clears the flag.
6. `rd_rst` asserted on beat 4 of a block with 3 blocks queued → after the edge, `o_byte_valid` = 0 and `count` = 0; a new block afterwards streams correctly from its first byte.
